jpeg_bitstream_sink: RTL and testbench

Receiving end of the jpeg_top output interface. Accepts 32-bit JPEG_bitstream words and the end-of-file partial word, buffers them in a word FIFO, and serialises them MSB-first into a byte-wide RAM write stream with ram_byte, ram_wren and ram_wraddr. At end of frame it reports frame_size. It gives design2 the same byte-RAM output as design1, so both encoders can be compared on one memory model.

---
 rtl/jpeg_bitstream_sink.sv | 212 +++++++++++++++++++++
 tb/tb_jpeg_bitstream_sink.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/jpeg_bitstream_sink.sv
// rtl/jpeg_bitstream_sink.sv - buffers JPEG bitstream words and serialises them MSB-first into byte RAM writes.
// Optional JPEG_EOI_APPEND_EN appends the FF D9 end-of-image marker after each frame's last byte.
module jpeg_bitstream_sink #(
    parameter int FIFO_DEPTH = 8,
    parameter int ADDR_W     = 24
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       bits_in,
    input  logic              bits_rdy,
    input  logic [4:0]        eof_cnt,
    input  logic              eof_p,
    input  logic              out_afull,
    output logic [7:0]        ram_byte,
    output logic              ram_wren,
    output logic [ADDR_W-1:0] ram_wraddr,
    output logic [ADDR_W-1:0] frame_size,
    output logic              frame_done,
    output logic              overflow,
    output logic              proto_err
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0] DEPTH_C = (PTR_W + 1)'(FIFO_DEPTH);

`ifdef JPEG_EOI_APPEND_EN
    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_EMIT, S_FIN, S_EOI1, S_EOI2} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_EMIT, S_FIN} state_t;
`endif

    // FIFO entry layout: {word[31:0], nbytes[2:0], last}
    logic [35:0]       r_fifo [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [PTR_W:0]    r_count;
    state_t            r_state;
    state_t            w_next;
    logic [31:0]       r_word;
    logic [2:0]        r_nbytes;
    logic              r_last;
    logic [1:0]        r_idx;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] r_last_addr;
    logic [7:0]        r_last_byte;
    logic [ADDR_W-1:0] r_frame_size;
    logic              r_frame_done;
    logic              r_overflow;
    logic              r_proto_err;

    logic              w_push_req;
    logic              w_full;
    logic              w_empty;
    logic              w_push;
    logic              w_pop;
    logic [5:0]        w_eof_sum;
    logic [31:0]       w_fill_mask;
    logic [35:0]       w_entry;
    logic [35:0]       w_head;
    logic [7:0]        w_cur_byte;
    logic              w_word_done;
    logic              w_wren;
    logic [7:0]        w_byte;
    logic              w_fin;

    assign w_push_req  = bits_rdy | eof_p;
    assign w_full      = (r_count == DEPTH_C);
    assign w_empty     = (r_count == '0);
    assign w_push      = w_push_req & ~w_full;
    assign w_pop       = (r_state == S_LOAD);
    assign w_eof_sum   = {1'b0, eof_cnt} + 6'd7;
    assign w_fill_mask = 32'hFFFF_FFFF >> eof_cnt;
    assign w_entry     = bits_rdy ? {bits_in, 3'd4, 1'b0}
                                  : {bits_in | w_fill_mask, w_eof_sum[5:3], 1'b1};
    assign w_head      = r_fifo[r_rd_ptr];
    assign w_word_done = ({1'b0, r_idx} == (r_nbytes - 3'd1));

    always_comb begin
        w_cur_byte = r_word[31:24];
        case (r_idx)
            2'd0: w_cur_byte = r_word[31:24];
            2'd1: w_cur_byte = r_word[23:16];
            2'd2: w_cur_byte = r_word[15:8];
            2'd3: w_cur_byte = r_word[7:0];
            default: w_cur_byte = r_word[31:24];
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_push) r_fifo[r_wr_ptr] <= w_entry;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_proto_err <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_push_req && w_full) r_overflow  <= 1'b1;
            if (bits_rdy && eof_p)    r_proto_err <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_next;
    end

    // A word is only taken from the FIFO while downstream can accept bytes,
    // so a stalled sink leaves every buffered word in the FIFO.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (!w_empty && !out_afull) w_next = S_LOAD;
            S_LOAD: w_next = (w_head[3:1] == 3'd0) ? S_FIN : S_EMIT;
            S_EMIT: begin
                if (!out_afull && w_word_done) begin
                    if (r_last) begin
`ifdef JPEG_EOI_APPEND_EN
                        w_next = S_EOI1;
`else
                        w_next = S_FIN;
`endif
                    end else begin
                        w_next = w_empty ? S_IDLE : S_LOAD;
                    end
                end
            end
`ifdef JPEG_EOI_APPEND_EN
            S_EOI1: if (!out_afull) w_next = S_EOI2;
            S_EOI2: if (!out_afull) w_next = S_FIN;
`endif
            S_FIN:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_wren = 1'b0;
        w_byte = 8'h00;
        w_fin  = 1'b0;
        case (r_state)
            S_EMIT: begin
                w_wren = ~out_afull;
                w_byte = w_cur_byte;
            end
`ifdef JPEG_EOI_APPEND_EN
            S_EOI1: begin
                w_wren = ~out_afull;
                w_byte = 8'hFF;
            end
            S_EOI2: begin
                w_wren = ~out_afull;
                w_byte = 8'hD9;
            end
`endif
            S_FIN:   w_fin = 1'b1;
            default: w_wren = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_word       <= '0;
            r_nbytes     <= '0;
            r_last       <= 1'b0;
            r_idx        <= '0;
            r_addr       <= '0;
            r_last_addr  <= '0;
            r_last_byte  <= '0;
            r_frame_size <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= w_fin;
            if (w_pop) begin
                r_word   <= w_head[35:4];
                r_nbytes <= w_head[3:1];
                r_last   <= w_head[0];
                r_idx    <= '0;
            end
            if (w_wren) begin
                r_addr      <= r_addr + 1'b1;
                r_last_addr <= r_addr;
                r_last_byte <= w_byte;
                if (r_state == S_EMIT) r_idx <= r_idx + 1'b1;
            end
            if (w_fin) begin
                r_frame_size <= r_addr;
                r_addr       <= '0;
            end
        end
    end

    // Between writes the byte/address outputs hold the last written pair.
    assign ram_wren   = w_wren;
    assign ram_byte   = w_wren ? w_byte : r_last_byte;
    assign ram_wraddr = w_wren ? r_addr : r_last_addr;
    assign frame_size = r_frame_size;
    assign frame_done = r_frame_done;
    assign overflow   = r_overflow;
    assign proto_err  = r_proto_err;

endmodule

// File: tb/tb_jpeg_bitstream_sink.sv
// tb/tb_jpeg_bitstream_sink.sv - directed self-checking bench for jpeg_bitstream_sink.
// Expected frame sizes and byte lists follow JPEG_EOI_APPEND_EN when it is defined.
module tb_jpeg_bitstream_sink;

`ifdef JPEG_EOI_APPEND_EN
    localparam int EOI_N = 2;
`else
    localparam int EOI_N = 0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] bits_in = '0;
    logic        bits_rdy = 1'b0;
    logic [4:0]  eof_cnt = '0;
    logic        eof_p = 1'b0;
    logic        out_afull = 1'b0;
    logic [7:0]  ram_byte;
    logic        ram_wren;
    logic [23:0] ram_wraddr;
    logic [23:0] frame_size;
    logic        frame_done;
    logic        overflow;
    logic        proto_err;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int done_cnt = 0;
    logic [23:0] last_fs = '0;
    logic [7:0]  q_byte[$];
    logic [23:0] q_addr[$];
    int          q_cyc[$];

    jpeg_bitstream_sink #(.FIFO_DEPTH(8), .ADDR_W(24)) dut (
        .clk(clk), .rst(rst), .bits_in(bits_in), .bits_rdy(bits_rdy),
        .eof_cnt(eof_cnt), .eof_p(eof_p), .out_afull(out_afull),
        .ram_byte(ram_byte), .ram_wren(ram_wren), .ram_wraddr(ram_wraddr),
        .frame_size(frame_size), .frame_done(frame_done),
        .overflow(overflow), .proto_err(proto_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (ram_wren) begin
            q_byte.push_back(ram_byte);
            q_addr.push_back(ram_wraddr);
            q_cyc.push_back(cyc);
        end
        if (frame_done) begin
            done_cnt = done_cnt + 1;
            last_fs  = frame_size;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_full(input logic [31:0] w, output int c);
        bits_in = w; bits_rdy = 1'b1;
        @(posedge clk); #1;
        c = cyc; bits_rdy = 1'b0;
    endtask

    task automatic push_eof(input logic [31:0] w, input logic [4:0] n);
        bits_in = w; eof_cnt = n; eof_p = 1'b1;
        @(posedge clk); #1;
        eof_p = 1'b0;
    endtask

    task automatic wait_bytes(input int n, input int budget);
        int k = 0;
        while (q_byte.size() < n && k < budget) begin
            @(posedge clk); #1;
            k++;
        end
    endtask

    task automatic wait_done(input int prev, input int budget);
        int k = 0;
        while (done_cnt == prev && k < budget) begin
            @(posedge clk); #1;
            k++;
        end
    endtask

    task automatic clear_q();
        q_byte.delete(); q_addr.delete(); q_cyc.delete();
    endtask

    task automatic check_stream(input string tag, input logic [7:0] eb[$], input int base);
        check({tag, " count"}, q_byte.size(), eb.size());
        for (int i = 0; i < eb.size() && i < q_byte.size(); i++) begin
            check($sformatf("%s byte%0d", tag, i), q_byte[i], eb[i]);
            check($sformatf("%s addr%0d", tag, i), q_addr[i], base + i);
        end
    endtask

    initial begin
        logic [7:0] eb[$];
        int pc;
        int d0;

        repeat (3) @(posedge clk);
        #1;
        check("reset wren", ram_wren, 0);
        check("reset byte", ram_byte, 0);
        check("reset addr", ram_wraddr, 0);
        check("reset fsize", frame_size, 0);
        check("reset fdone", frame_done, 0);
        check("reset ovf", overflow, 0);
        check("reset perr", proto_err, 0);
        rst = 1'b1;
        @(posedge clk); #1;

        // full word + 12-bit partial word, low nibble filled with ones
        d0 = done_cnt;
        push_full(32'h12345678, pc);
        push_eof(32'hABC00000, 5'd12);
        wait_bytes(6 + EOI_N, 60);
        wait_done(d0, 30);
        eb = '{8'h12, 8'h34, 8'h56, 8'h78, 8'hAB, 8'hCF};
        if (EOI_N == 2) begin eb.push_back(8'hFF); eb.push_back(8'hD9); end
        check_stream("t1", eb, 0);
        check("t1 done", done_cnt, d0 + 1);
        check("t1 fsize", last_fs, 6 + EOI_N);

        // single word latency: writes at push+2 .. push+5
        clear_q();
        push_full(32'hDEADBEEF, pc);
        wait_bytes(4, 30);
        eb = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
        check_stream("t2", eb, 0);
        check("t2 first cyc", (q_cyc.size() > 0) ? q_cyc[0] : -1, pc + 2);
        check("t2 last cyc", (q_cyc.size() > 3) ? q_cyc[3] : -1, pc + 5);

        // stall mid-word, then eof_cnt=0 closes an 8-byte frame
        clear_q();
        d0 = done_cnt;
        push_full(32'h0BADF00D, pc);
        push_eof(32'h00000000, 5'd0);
        wait_bytes(2, 30);
        out_afull = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("t3 stall count", q_byte.size(), 2);
        out_afull = 1'b0;
        wait_bytes(4 + EOI_N, 40);
        wait_done(d0, 30);
        eb = '{8'h0B, 8'hAD, 8'hF0, 8'h0D};
        if (EOI_N == 2) begin eb.push_back(8'hFF); eb.push_back(8'hD9); end
        check_stream("t3", eb, 4);
        check("t5 done", done_cnt, d0 + 1);
        check("t5 fsize", last_fs, 8 + EOI_N);

        // overflow: 10 words while stalled, 8 survive, frame restarts at 0
        clear_q();
        d0 = done_cnt;
        out_afull = 1'b1;
        for (int k = 0; k < 10; k++) push_full(32'h10203040 + k * 32'h01010101, pc);
        repeat (3) @(posedge clk);
        #1;
        check("t4 ovf", overflow, 1);
        check("t4 no write", q_byte.size(), 0);
        out_afull = 1'b0;
        wait_bytes(32, 200);
        repeat (20) @(posedge clk);
        #1;
        eb.delete();
        for (int k = 0; k < 8; k++) begin
            eb.push_back(8'h10 + 8'(k)); eb.push_back(8'h20 + 8'(k));
            eb.push_back(8'h30 + 8'(k)); eb.push_back(8'h40 + 8'(k));
        end
        check_stream("t4", eb, 0);
        check("t4 no done", done_cnt, d0);

        // bits_rdy and eof_p together: only the full word is kept
        clear_q();
        bits_in = 32'hCAFEBABE; eof_cnt = 5'd8; bits_rdy = 1'b1; eof_p = 1'b1;
        @(posedge clk); #1;
        bits_rdy = 1'b0; eof_p = 1'b0;
        wait_bytes(4, 30);
        repeat (10) @(posedge clk);
        #1;
        eb = '{8'hCA, 8'hFE, 8'hBA, 8'hBE};
        check_stream("t6", eb, 32);
        check("t6 perr", proto_err, 1);
        check("t6 no done", done_cnt, d0);

        // reset while emitting
        clear_q();
        push_full(32'h11223344, pc);
        wait_bytes(1, 30);
        rst = 1'b0;
        #1;
        check("rst wren", ram_wren, 0);
        check("rst byte", ram_byte, 0);
        check("rst addr", ram_wraddr, 0);
        check("rst fsize", frame_size, 0);
        check("rst ovf", overflow, 0);
        check("rst perr", proto_err, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        clear_q();
        d0 = done_cnt;
        push_full(32'h55667788, pc);
        push_eof(32'h99000000, 5'd8);
        wait_bytes(5 + EOI_N, 60);
        wait_done(d0, 30);
        eb = '{8'h55, 8'h66, 8'h77, 8'h88, 8'h99};
        if (EOI_N == 2) begin eb.push_back(8'hFF); eb.push_back(8'hD9); end
        check_stream("t7", eb, 0);
        check("t7 done", done_cnt, d0 + 1);
        check("t7 fsize", last_fs, 5 + EOI_N);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
